rob_alloc_ctrl: RTL and testbench
=================================

Name: rob_alloc_ctrl

Overview:
- Reorder-buffer allocation controller. Owns the ROB head and tail pointers and the occupancy count.
- Hands out up to two in-order ROB indices per cycle to dispatch, and reclaims entries using the retire count reported by the ROB.
- Sits between rename/dispatch and the rob block, driving its rob_index_1/rob_index_2 inputs.
- Provides stall back-pressure, a flush sequence, and a sticky protocol-error flag.

Parameters:
- DEPTH, 32, number of ROB entries (power of two).
- IDX_W, 5, index width, log2(DEPTH).
- CNT_W, 6, occupancy counter width, log2(DEPTH)+1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- alloc_req_1  input  1  dispatch slot 1 requests an entry.
- alloc_req_2  input  1  dispatch slot 2 requests an entry.
- num_retired  input  2  entries retired by the ROB this cycle (0..2).
- flush  input  1  single-cycle pulse: discard all in-flight entries.
- alloc_grant_1  output  1  slot 1 granted (combinational).
- alloc_grant_2  output  1  slot 2 granted (combinational).
- rob_index_1  output  IDX_W  index for slot 1, equal to tail.
- rob_index_2  output  IDX_W  index for slot 2, equal to (tail+1) mod DEPTH.
- head_o  output  IDX_W  oldest live entry.
- count_o  output  CNT_W  live entries, 0..DEPTH.
- empty  output  1  count_o == 0.
- full  output  1  count_o == DEPTH.
- stall  output  1  a request was raised but not fully granted this cycle.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (asynchronous, active-high): head=0, tail=0, count=0, state=S_RUN, err=0. Outputs follow: grants 0, stall 0, empty 1, full 0.
- FSM states:
  - S_RUN: normal operation.
  - S_FLUSH: one cycle; all grants forced 0, stall=1.
  - S_ERR: terminal until reset.
- FSM transitions:
  - S_RUN → S_FLUSH on flush=1.
  - S_FLUSH → S_RUN unconditionally.
  - Any state → S_ERR on a protocol error. S_ERR takes priority over S_FLUSH when both occur in the same cycle.
- Availability: free = DEPTH - count, using the registered count only. Entries retired in cycle N become allocatable in cycle N+1; there is no same-cycle bypass.
- Grant rules in S_RUN, evaluated combinationally from registered state:
  - alloc_grant_1 = alloc_req_1 && free >= 1.
  - alloc_grant_2 = alloc_req_2 && alloc_req_1 && free >= 2.
  - alloc_req_2 without alloc_req_1 is ignored; it is not granted and does not count toward stall.
  - Grants are in order: grant_2 is never 1 while grant_1 is 0.
- stall = (alloc_req_1 && !alloc_grant_1) || (alloc_req_1 && alloc_req_2 && !alloc_grant_2), and is also 1 throughout S_FLUSH and S_ERR.
- Update at posedge, when in S_RUN with no flush:
  - tail += grant_1 + grant_2, mod DEPTH (natural IDX_W wrap).
  - head += num_retired, mod DEPTH.
  - count = count + grants - num_retired.
- Simultaneous allocate and retire: both are applied in the same edge. With count=DEPTH, num_retired=2 and requests present, the grants are 0 this cycle and count becomes DEPTH-2.
- Flush: in the flush cycle, grants are forced 0. At the edge, head=tail=0, count=0, and the state moves to S_FLUSH. num_retired in the flush cycle is ignored.
- Protocol errors, which set err and enter S_ERR:
  - num_retired == 3.
  - num_retired > count.
- In S_ERR: pointers and count freeze, grants are 0, and stall=1.
- Invariant checked by assertion: count == (tail - head) mod DEPTH, except count==DEPTH when head==tail and the buffer is full.
- Latency: grant and index are valid in the request cycle. Count, full and empty reflect the change one cycle later.

Decomposition:
- Shared package respackage holds:
  - ROB_DEPTH=32, ROB_IDX_W=5, ROB_CNT_W=6.
  - typedef enum alloc_state_t {S_RUN, S_FLUSH, S_ERR}.
- The module's parameters default from these constants.
- Single module; no sub-module is needed. The pointer/count datapath and the FSM stay together.

Test Plan:
- Reset, then alloc_req_1=1 and alloc_req_2=1 each cycle with num_retired=0 → indices 0/1, 2/3, … 30/31. After 16 cycles full=1, count_o=32. Cycle 17: grants 0, stall=1.
- From full, num_retired=1 with both requests → grants 0 that cycle. Next cycle grant_1=1, grant_2=0, rob_index_1=0 (wrapped), stall=1; count returns to 32.
- Count=31 with both requests → grant_1=1, grant_2=0, rob_index_1=31. tail wraps to 0, count=32.
- Count=10 with both requests and num_retired=2 at the same time → count=10; head and tail each advance by 2.
- Count=20, flush pulse with alloc_req_1=1 → grants 0 in the flush cycle. Next cycle head=tail=0, count=0, stall=1 (S_FLUSH). The cycle after, grant_1=1 with rob_index_1=0.
- Count=1, num_retired=2 → err=1, stall=1, count frozen at 1. Later requests are never granted; asserting reset mid-operation clears err and count asynchronously.

Source files
------------

// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared constants and FSM state type for the ROB allocation controller.
// No logic and no latency; constants only.
// No backpressure; the package carries no handshake.
package respackage;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = 5;
  localparam int ROB_CNT_W = 6;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_ERR   = 2'd2
  } alloc_state_t;

endpackage

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation controller: owns head/tail/count and hands out up to two in-order indices per cycle.
// Latency: grants and indices are combinational in the request cycle; count/full/empty update one edge later.
// Backpressure: stall whenever a valid request is not fully granted, and throughout flush and error states.
module rob_alloc_ctrl
  import respackage::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W,
  parameter int CNT_W = ROB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req_1,
  input  logic             alloc_req_2,
  input  logic [1:0]       num_retired,
  input  logic             flush,
  output logic             alloc_grant_1,
  output logic             alloc_grant_2,
  output logic [IDX_W-1:0] rob_index_1,
  output logic [IDX_W-1:0] rob_index_2,
  output logic [IDX_W-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty,
  output logic             full,
  output logic             stall,
  output logic             err
);

  alloc_state_t     state_q, state_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] free_w;
  logic             proto_err;
  logic             can_alloc;
  logic             grant_1;
  logic             grant_2;
  logic             stall_w;

  // Free space comes from the registered count only: a retire this cycle
  // frees its entries for the next cycle, never the current one.
  assign free_w = CNT_W'(DEPTH) - count_q;

  // Retiring more than is live, or the illegal encoding 3, is a protocol
  // violation regardless of state.
  assign proto_err = (num_retired == 2'd3) || (CNT_W'(num_retired) > count_q);

  // Allocation is only honoured when the edge will actually record it;
  // a grant in a cycle that flushes or errors would hand out a phantom index.
  assign can_alloc = (state_q == S_RUN) && !flush && !proto_err;

  // Combinational in-order grants; slot 2 is only considered alongside slot 1.
  always_comb begin
    grant_1 = 1'b0;
    grant_2 = 1'b0;
    if (can_alloc) begin
      grant_1 = alloc_req_1 && (free_w >= CNT_W'(1));
      grant_2 = alloc_req_1 && alloc_req_2 && (free_w >= CNT_W'(2));
    end
  end

  // Stall reports any unmet request; a lone slot-2 request is ignored.
  always_comb begin
    stall_w = 1'b1;
    if (state_q == S_RUN) begin
      stall_w = (alloc_req_1 && !grant_1) ||
                (alloc_req_1 && alloc_req_2 && !grant_2);
    end
  end

  // Next-state for FSM, pointers, count and the sticky error flag.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;

    if (proto_err) begin
      // Error wins over flush; everything else freezes.
      state_d = S_ERR;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (flush) begin
            // Retire count is discarded along with every in-flight entry.
            state_d = S_FLUSH;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
          end else begin
            tail_d  = tail_q + IDX_W'(grant_1) + IDX_W'(grant_2);
            head_d  = head_q + IDX_W'(num_retired);
            count_d = count_q + CNT_W'(grant_1) + CNT_W'(grant_2)
                      - CNT_W'(num_retired);
          end
        end
        S_FLUSH: begin
          state_d = S_RUN;
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  // State register with asynchronous reset to an empty buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign alloc_grant_1 = grant_1;
  assign alloc_grant_2 = grant_2;
  assign rob_index_1   = tail_q;
  assign rob_index_2   = tail_q + IDX_W'(1);
  assign head_o        = head_q;
  assign count_o       = count_q;
  assign empty         = (count_q == '0);
  assign full          = (count_q == CNT_W'(DEPTH));
  assign stall         = stall_w;
  assign err           = err_q;

  // Occupancy must match the pointer distance; a full buffer aliases to
  // head == tail, which the low-bit comparison covers.
  a_count_matches_ptrs : assert property (
    @(posedge clk) disable iff (reset)
      (count_q <= CNT_W'(DEPTH)) &&
      (count_q[IDX_W-1:0] == IDX_W'(tail_q - head_q))
  );

  // Grants are handed out strictly in order.
  a_grant_in_order : assert property (
    @(posedge clk) disable iff (reset)
      !(alloc_grant_2 && !alloc_grant_1)
  );

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Self-checking bench for rob_alloc_ctrl with a reference model and scoreboard queues.
// Inputs driven on the falling edge; combinational outputs sampled 2ns later, registered ones 1ns after the rising edge.
// Each test task drains the scoreboard and performs its own comparisons.
module tb_rob_alloc_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alloc_req_1 = 1'b0;
  logic       alloc_req_2 = 1'b0;
  logic [1:0] num_retired = 2'd0;
  logic       flush = 1'b0;
  logic       alloc_grant_1, alloc_grant_2;
  logic [4:0] rob_index_1, rob_index_2, head_o;
  logic [5:0] count_o;
  logic       empty, full, stall, err;

  rob_alloc_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_req_1   (alloc_req_1),
    .alloc_req_2   (alloc_req_2),
    .num_retired   (num_retired),
    .flush         (flush),
    .alloc_grant_1 (alloc_grant_1),
    .alloc_grant_2 (alloc_grant_2),
    .rob_index_1   (rob_index_1),
    .rob_index_2   (rob_index_2),
    .head_o        (head_o),
    .count_o       (count_o),
    .empty         (empty),
    .full          (full),
    .stall         (stall),
    .err           (err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: 0 = run, 1 = flush, 2 = error.
  int   m_head, m_tail, m_count, m_state;
  logic m_err;

  typedef struct packed {
    logic       g1;
    logic       g2;
    logic [4:0] i1;
    logic [4:0] i2;
    logic       st;
  } comb_t;

  typedef struct packed {
    logic [4:0] hd;
    logic [5:0] cnt;
    logic       emp;
    logic       ful;
    logic       er;
  } regs_t;

  comb_t exp_c[$], obs_c[$];
  regs_t exp_r[$], obs_r[$];

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_count = 0; m_state = 0; m_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    alloc_req_1 = 1'b0; alloc_req_2 = 1'b0; num_retired = 2'd0; flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle of stimulus: push the model's expectation, record what the DUT shows.
  task automatic step(input logic r1, input logic r2, input logic [1:0] nr, input logic fl);
    comb_t e, o;
    regs_t er, orr;
    logic  perr, run;
    int    free;
    @(negedge clk);
    alloc_req_1 = r1; alloc_req_2 = r2; num_retired = nr; flush = fl;
    perr = (nr == 2'd3) || (int'(nr) > m_count);
    run  = (m_state == 0) && !fl && !perr;
    free = 32 - m_count;
    e.g1 = run && r1 && (free >= 1);
    e.g2 = run && r1 && r2 && (free >= 2);
    e.i1 = 5'(m_tail);
    e.i2 = 5'((m_tail + 1) % 32);
    e.st = (m_state != 0) || (r1 && !e.g1) || (r1 && r2 && !e.g2);
    exp_c.push_back(e);
    #2;
    o.g1 = alloc_grant_1; o.g2 = alloc_grant_2;
    o.i1 = rob_index_1;   o.i2 = rob_index_2; o.st = stall;
    obs_c.push_back(o);
    @(posedge clk);
    if (perr) begin
      m_state = 2; m_err = 1'b1;
    end else if (m_state == 0 && fl) begin
      m_head = 0; m_tail = 0; m_count = 0; m_state = 1;
    end else if (m_state == 0) begin
      m_tail  = (m_tail + int'(e.g1) + int'(e.g2)) % 32;
      m_head  = (m_head + int'(nr)) % 32;
      m_count = m_count + int'(e.g1) + int'(e.g2) - int'(nr);
    end else if (m_state == 1) begin
      m_state = 0;
    end
    #1;
    er.hd = 5'(m_head); er.cnt = 6'(m_count);
    er.emp = (m_count == 0); er.ful = (m_count == 32); er.er = m_err;
    exp_r.push_back(er);
    orr.hd = head_o; orr.cnt = count_o; orr.emp = empty; orr.ful = full; orr.er = err;
    obs_r.push_back(orr);
    alloc_req_1 = 1'b0; alloc_req_2 = 1'b0; num_retired = 2'd0; flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({alloc_grant_1, alloc_grant_2, stall, empty, full, err} !== 6'b000100)
      $display("FAIL reset_flags: got g1g2 stall empty full err=%b, want 000100",
               {alloc_grant_1, alloc_grant_2, stall, empty, full, err});
    else passed++;
    total++;
    if (count_o !== 6'd0 || head_o !== 5'd0)
      $display("FAIL reset_ptrs: got count=%0d head=%0d, want 0/0", count_o, head_o);
    else passed++;
    total++;
    if (rob_index_1 !== 5'd0 || rob_index_2 !== 5'd1)
      $display("FAIL reset_idx: got %0d/%0d, want 0/1", rob_index_1, rob_index_2);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    total++;
    if (count_o !== 6'd32 || full !== 1'b1)
      $display("FAIL fill_full: got count=%0d full=%b, want 32/1", count_o, full);
    else passed++;
    step(1'b1, 1'b1, 2'd0, 1'b0);
    total++;
    if (obs_c[16].g1 !== 1'b0 || obs_c[16].st !== 1'b1)
      $display("FAIL fill_overflow: got g1=%b stall=%b, want 0/1", obs_c[16].g1, obs_c[16].st);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (obs_c[i].i1 !== 5'(2*i) || obs_c[i].i2 !== 5'(2*i+1))
        $display("FAIL fill_idx%0d: got %0d/%0d, want %0d/%0d", i, obs_c[i].i1, obs_c[i].i2, 2*i, 2*i+1);
      else passed++;
    end
    while (exp_c.size() > 0) begin
      comb_t e, o;
      regs_t er, orr;
      e = exp_c.pop_front(); o = obs_c.pop_front();
      er = exp_r.pop_front(); orr = obs_r.pop_front();
      total++;
      if (o !== e || orr !== er)
        $display("FAIL fill_sb: got comb=%h regs=%h, want comb=%h regs=%h", o, orr, e, er);
      else passed++;
    end
  endtask

  // Continues from the full buffer left by test_fill.
  task automatic test_full_retire();
    step(1'b1, 1'b1, 2'd1, 1'b0);
    step(1'b1, 1'b1, 2'd0, 1'b0);
    total++;
    if (obs_c[0].g1 !== 1'b0 || obs_c[0].g2 !== 1'b0)
      $display("FAIL full_retire_same: got g1=%b g2=%b, want 0/0", obs_c[0].g1, obs_c[0].g2);
    else passed++;
    total++;
    if (obs_c[1] !== {1'b1, 1'b0, 5'd0, 5'd1, 1'b1})
      $display("FAIL full_retire_next: got %h, want g1=1 g2=0 idx=0/1 stall=1", obs_c[1]);
    else passed++;
    total++;
    if (count_o !== 6'd32 || head_o !== 5'd1)
      $display("FAIL full_retire_cnt: got count=%0d head=%0d, want 32/1", count_o, head_o);
    else passed++;
    while (exp_c.size() > 0) begin
      comb_t e, o;
      regs_t er, orr;
      e = exp_c.pop_front(); o = obs_c.pop_front();
      er = exp_r.pop_front(); orr = obs_r.pop_front();
      total++;
      if (o !== e || orr !== er)
        $display("FAIL full_retire_sb: got comb=%h regs=%h, want comb=%h regs=%h", o, orr, e, er);
      else passed++;
    end
  endtask

  task automatic test_wrap31();
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 1'b0);
    total++;
    if (obs_c[16] !== {1'b1, 1'b0, 5'd31, 5'd0, 1'b1})
      $display("FAIL wrap31: got %h, want g1=1 g2=0 idx=31/0 stall=1", obs_c[16]);
    else passed++;
    total++;
    if (count_o !== 6'd32 || rob_index_1 !== 5'd0)
      $display("FAIL wrap31_after: got count=%0d tail=%0d, want 32/0", count_o, rob_index_1);
    else passed++;
    while (exp_c.size() > 0) begin
      comb_t e, o;
      regs_t er, orr;
      e = exp_c.pop_front(); o = obs_c.pop_front();
      er = exp_r.pop_front(); orr = obs_r.pop_front();
      total++;
      if (o !== e || orr !== er)
        $display("FAIL wrap31_sb: got comb=%h regs=%h, want comb=%h regs=%h", o, orr, e, er);
      else passed++;
    end
  endtask

  task automatic test_simul_retire();
    do_reset();
    step(1'b0, 1'b1, 2'd0, 1'b0);
    total++;
    if (obs_c[0].g2 !== 1'b0 || obs_c[0].st !== 1'b0 || count_o !== 6'd0)
      $display("FAIL req2_only: got g2=%b stall=%b count=%0d, want 0/0/0", obs_c[0].g2, obs_c[0].st, count_o);
    else passed++;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b1, 1'b1, 2'd2, 1'b0);
    total++;
    if (count_o !== 6'd10 || head_o !== 5'd2 || rob_index_1 !== 5'd12)
      $display("FAIL simul: got count=%0d head=%0d tail=%0d, want 10/2/12", count_o, head_o, rob_index_1);
    else passed++;
    while (exp_c.size() > 0) begin
      comb_t e, o;
      regs_t er, orr;
      e = exp_c.pop_front(); o = obs_c.pop_front();
      er = exp_r.pop_front(); orr = obs_r.pop_front();
      total++;
      if (o !== e || orr !== er)
        $display("FAIL simul_sb: got comb=%h regs=%h, want comb=%h regs=%h", o, orr, e, er);
      else passed++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b1, 1'b0, 2'd1, 1'b1);
    total++;
    if (obs_c[10].g1 !== 1'b0 || count_o !== 6'd0 || head_o !== 5'd0)
      $display("FAIL flush_cycle: got g1=%b count=%0d head=%0d, want 0/0/0", obs_c[10].g1, count_o, head_o);
    else passed++;
    step(1'b1, 1'b0, 2'd0, 1'b0);
    total++;
    if (obs_c[11].g1 !== 1'b0 || obs_c[11].st !== 1'b1 || obs_c[11].i1 !== 5'd0)
      $display("FAIL flush_state: got g1=%b stall=%b tail=%0d, want 0/1/0", obs_c[11].g1, obs_c[11].st, obs_c[11].i1);
    else passed++;
    step(1'b1, 1'b0, 2'd0, 1'b0);
    total++;
    if (obs_c[12].g1 !== 1'b1 || obs_c[12].i1 !== 5'd0)
      $display("FAIL flush_resume: got g1=%b idx=%0d, want 1/0", obs_c[12].g1, obs_c[12].i1);
    else passed++;
    while (exp_c.size() > 0) begin
      comb_t e, o;
      regs_t er, orr;
      e = exp_c.pop_front(); o = obs_c.pop_front();
      er = exp_r.pop_front(); orr = obs_r.pop_front();
      total++;
      if (o !== e || orr !== er)
        $display("FAIL flush_sb: got comb=%h regs=%h, want comb=%h regs=%h", o, orr, e, er);
      else passed++;
    end
  endtask

  task automatic test_err();
    do_reset();
    step(1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd2, 1'b0);
    total++;
    if (err !== 1'b1 || count_o !== 6'd1)
      $display("FAIL err_over_retire: got err=%b count=%0d, want 1/1", err, count_o);
    else passed++;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    total++;
    if (obs_c[4].g1 !== 1'b0 || obs_c[4].st !== 1'b1 || count_o !== 6'd1)
      $display("FAIL err_frozen: got g1=%b stall=%b count=%0d, want 0/1/1", obs_c[4].g1, obs_c[4].st, count_o);
    else passed++;
    // Asynchronous reset in the middle of a cycle, no clock edge involved.
    reset = 1'b1;
    #1;
    total++;
    if (err !== 1'b0 || count_o !== 6'd0)
      $display("FAIL err_async_reset: got err=%b count=%0d, want 0/0", err, count_o);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd3, 1'b0);
    total++;
    if (err !== 1'b1 || count_o !== 6'd4)
      $display("FAIL err_retire3: got err=%b count=%0d, want 1/4", err, count_o);
    else passed++;
    do_reset();
    step(1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd3, 1'b1);
    total++;
    if (err !== 1'b1 || count_o !== 6'd2)
      $display("FAIL err_beats_flush: got err=%b count=%0d, want 1/2", err, count_o);
    else passed++;
    while (exp_c.size() > 0) begin
      comb_t e, o;
      regs_t er, orr;
      e = exp_c.pop_front(); o = obs_c.pop_front();
      er = exp_r.pop_front(); orr = obs_r.pop_front();
      total++;
      if (o !== e || orr !== er)
        $display("FAIL err_sb: got comb=%h regs=%h, want comb=%h regs=%h", o, orr, e, er);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] nr;
    int         lim;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      lim = (m_count < 2) ? m_count : 2;
      nr  = 2'($urandom_range(0, lim));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nr,
           1'($urandom_range(0, 24) == 0));
    end
    while (exp_c.size() > 0) begin
      comb_t e, o;
      regs_t er, orr;
      e = exp_c.pop_front(); o = obs_c.pop_front();
      er = exp_r.pop_front(); orr = obs_r.pop_front();
      total++;
      if (o !== e || orr !== er)
        $display("FAIL b2b_sb: got comb=%h regs=%h, want comb=%h regs=%h", o, orr, e, er);
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    test_reset();
    test_fill();
    test_full_retire();
    test_wrap31();
    test_simul_retire();
    test_flush();
    test_err();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
